// File: rtl/uart_tx_arb_if.sv
// Requester and transmitter-read-port bundle for uart_tx_arb; signal suffixes are
// relative to the arbiter, which connects through the slave modport.
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic                 tx_empty_o;
  logic                 tx_re_i;
  logic [7:0]           tx_data_o;

  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_re_i,
    input  req_ready_o, tx_empty_o, tx_data_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_re_i,
    output req_ready_o, tx_empty_o, tx_data_o
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin, message-locked arbiter feeding one UART TX through a 1-entry stage (read latency 1);
// a requester is stalled while the stage is full and not being read. UART_TX_ARB_TIMEOUT_EN adds a forced unlock.
module uart_tx_arb #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arb_if.slave       bus,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               busy_o,
  output logic               timeout_o
);
  localparam int IDXW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("uart_tx_arb: parameter out of range");
  end

  typedef enum logic {IDLE, LOCK} state_e;

  state_e             state_q, state_d;
  logic [IDXW-1:0]    rr_q, rr_d, gidx_q, gidx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         stage_data_q, stage_data_d, tx_data_q, tx_data_d;
  logic               stage_vld_q, stage_vld_d;
  logic               timeout_q, timeout_d;

  logic [IDXW-1:0]    win_idx, cidx, gnext;
  logic [IDXW:0]      sum;
  logic               win_vld;
  logic               g_vld, g_last, g_rdy, acc, pop, expire;
  logic [7:0]         g_dat;
  logic [NUM_REQ-1:0] ready;

  assign g_vld  = bus.req_valid_i[gidx_q];
  assign g_last = bus.req_last_i[gidx_q];
  assign g_dat  = bus.req_data_i[{gidx_q, 3'b000} +: 8];
  assign g_rdy  = !stage_vld_q || bus.tx_re_i;
  assign acc    = (state_q == LOCK) && g_vld && g_rdy;
  assign pop    = bus.tx_re_i && stage_vld_q;
  assign gnext  = (gidx_q == IDXW'(NUM_REQ - 1)) ? '0 : gidx_q + IDXW'(1);

  // First valid requester at or above rr, wrapping past NUM_REQ-1.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    cidx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_q} + (IDXW+1)'(i);
      if (sum >= (IDXW+1)'(NUM_REQ)) sum = sum - (IDXW+1)'(NUM_REQ);
      cidx = sum[IDXW-1:0];
      if (!win_vld && bus.req_valid_i[cidx]) begin
        win_vld = 1'b1;
        win_idx = cidx;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != LOCK || acc) to_cnt_d = '0;
    else if (!g_vld)            to_cnt_d = to_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end

  assign expire = (state_q == LOCK) && !g_vld && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gidx_d       = gidx_q;
    grant_d      = grant_q;
    stage_data_d = stage_data_q;
    stage_vld_d  = stage_vld_q;
    tx_data_d    = tx_data_q;
    timeout_d    = 1'b0;
    ready        = '0;

    if (pop) begin
      tx_data_d   = stage_data_q;
      stage_vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = LOCK;
          gidx_d  = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
        end
      end
      LOCK: begin
        ready[gidx_q] = g_rdy;
        // An accepted byte overrides a pending expiry.
        if (acc) begin
          stage_data_d = g_dat;
          stage_vld_d  = 1'b1;
          if (g_last) begin
            state_d = IDLE;
            rr_d    = gnext;
            grant_d = '0;
          end
        end else if (expire) begin
          state_d   = IDLE;
          rr_d      = gnext;
          grant_d   = '0;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      gidx_q       <= '0;
      grant_q      <= '0;
      stage_data_q <= '0;
      stage_vld_q  <= 1'b0;
      tx_data_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gidx_q       <= gidx_d;
      grant_q      <= grant_d;
      stage_data_q <= stage_data_d;
      stage_vld_q  <= stage_vld_d;
      tx_data_q    <= tx_data_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.tx_empty_o  = !stage_vld_q;
  assign bus.tx_data_o   = tx_data_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q == LOCK) || stage_vld_q;
  assign timeout_o       = timeout_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with two requesters; the timeout section expects a
// forced unlock only when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arb;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  logic       busy, timeout;
  int         n_tests = 0;
  int         n_fail  = 0;

  uart_tx_arb_if #(.NUM_REQ(2)) bus ();

  uart_tx_arb #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_o   (grant),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  // Round-robin table: expected grant/tx_data after edge i, then inputs applied for edge i+1.
  logic [1:0] g_exp [13] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
  logic [7:0] t_exp [13] = '{8'h00, 8'h00, 8'hA0, 8'hA1, 8'hA1, 8'hB0, 8'hB1, 8'hB1, 8'hA2, 8'hA3, 8'hA3, 8'hB2, 8'hB3};
  logic [1:0] v_tab [13] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
  logic [7:0] d0_tab[13] = '{8'hA0, 8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA3, 8'hA3, 8'hA3, 8'hA3, 8'hA3, 8'hA3};
  logic       l0_tab[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] d1_tab[13] = '{8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB1, 8'hB2, 8'hB2, 8'hB2, 8'hB2, 8'hB2, 8'hB3, 8'hB3, 8'hB3};
  logic       l1_tab[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic l0,
                       input logic [7:0] d1, input logic l1);
    bus.req_valid_i = v;
    bus.req_data_i  = {d1, d0};
    bus.req_last_i  = {l1, l0};
  endtask

  initial begin
    bus.tx_re_i = 1'b0;
    drive(2'b11, 8'h00, 1'b0, 8'h00, 1'b0);

    // Reset with all requesters asserting valid
    rst = 1'b1;
    step();
    step();
    chk("rst_empty", 32'(bus.tx_empty_o), 32'h1);
    chk("rst_data",  32'(bus.tx_data_o),  32'h00);
    chk("rst_grant", 32'(grant),          32'h0);
    chk("rst_ready", 32'(bus.req_ready_o), 32'h0);
    chk("rst_busy",  32'(busy),           32'h0);
    chk("rst_tmo",   32'(timeout),        32'h0);

    // Single message from requester 0
    rst = 1'b0;
    drive(2'b01, 8'h41, 1'b0, 8'h00, 1'b0);
    step();
    chk("msg_grant0", 32'(grant), 32'h1);
    chk("msg_ready0", 32'(bus.req_ready_o), 32'h1);
    step();
    drive(2'b01, 8'h42, 1'b0, 8'h00, 1'b0);
    #1;
    chk("msg_full_empty", 32'(bus.tx_empty_o), 32'h0);
    chk("msg_full_ready", 32'(bus.req_ready_o), 32'h0);
    repeat (5) step();
    chk("msg_grant_hold", 32'(grant), 32'h1);
    bus.tx_re_i = 1'b1;
    #1;
    chk("msg_ready_re", 32'(bus.req_ready_o), 32'h1);
    step();
    bus.tx_re_i = 1'b0;
    drive(2'b01, 8'h43, 1'b1, 8'h00, 1'b0);
    chk("msg_rd41", 32'(bus.tx_data_o), 32'h41);
    repeat (5) step();
    bus.tx_re_i = 1'b1;
    step();
    bus.tx_re_i = 1'b0;
    drive(2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("msg_rd42",       32'(bus.tx_data_o), 32'h42);
    chk("msg_grant_drop", 32'(grant), 32'h0);
    chk("msg_busy_stage", 32'(busy),  32'h1);
    bus.tx_re_i = 1'b1;
    step();
    bus.tx_re_i = 1'b0;
    chk("msg_rd43",   32'(bus.tx_data_o), 32'h43);
    chk("msg_empty",  32'(bus.tx_empty_o), 32'h1);
    chk("msg_idle",   32'(busy), 32'h0);

    // Round robin, both requesters streaming 2-byte messages, reader always enabled
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.tx_re_i = 1'b1;
    drive(2'b11, 8'hA0, 1'b0, 8'hB0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      step();
      chk($sformatf("rr_grant_%0d", i), 32'(grant), 32'(g_exp[i]));
      chk($sformatf("rr_data_%0d", i),  32'(bus.tx_data_o), 32'(t_exp[i]));
      drive(v_tab[i], d0_tab[i], l0_tab[i], d1_tab[i], l1_tab[i]);
    end
    bus.tx_re_i = 1'b0;

    // Simultaneous pop and push
    drive(2'b01, 8'h55, 1'b0, 8'h00, 1'b0);
    step();
    chk("pp_grant", 32'(grant), 32'h1);
    step();
    drive(2'b01, 8'h66, 1'b0, 8'h00, 1'b0);
    bus.tx_re_i = 1'b1;
    #1;
    chk("pp_ready", 32'(bus.req_ready_o), 32'h1);
    step();
    bus.tx_re_i = 1'b0;
    drive(2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("pp_rd55",  32'(bus.tx_data_o), 32'h55);
    chk("pp_empty", 32'(bus.tx_empty_o), 32'h0);
    bus.tx_re_i = 1'b1;
    step();
    bus.tx_re_i = 1'b0;
    chk("pp_rd66",     32'(bus.tx_data_o), 32'h66);
    chk("pp_empty2",   32'(bus.tx_empty_o), 32'h1);
    chk("pp_lock_busy", 32'(busy), 32'h1);

    // Read with empty stage is ignored
    bus.tx_re_i = 1'b1;
    step();
    bus.tx_re_i = 1'b0;
    chk("er_data",  32'(bus.tx_data_o), 32'h66);
    chk("er_empty", 32'(bus.tx_empty_o), 32'h1);

    // Reset during the second byte of a message
    drive(2'b01, 8'h77, 1'b0, 8'h00, 1'b0);
    step();
    drive(2'b01, 8'h78, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
    #1;
    chk("mr_empty", 32'(bus.tx_empty_o), 32'h1);
    chk("mr_data",  32'(bus.tx_data_o),  32'h00);
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_busy",  32'(busy),  32'h0);
    chk("mr_ready", 32'(bus.req_ready_o), 32'h0);
    drive(2'b11, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    chk("mr_rr0", 32'(grant), 32'h1);

    // Requester 1 sends one non-last byte then goes silent
    rst = 1'b1;
    drive(2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    rst = 1'b0;
    drive(2'b10, 8'h00, 1'b0, 8'hC1, 1'b0);
    step();
    chk("to_grant1", 32'(grant), 32'h2);
    step();
    drive(2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("to_pulse_%0d", i), 32'(timeout), 32'(TO_EN && i == 8));
      chk($sformatf("to_grant_%0d", i), 32'(grant), (TO_EN && i >= 8) ? 32'h0 : 32'h2);
    end
    drive(2'b01, 8'hD0, 1'b0, 8'h00, 1'b0);
    step();
    chk("to_next_grant", 32'(grant), TO_EN ? 32'h1 : 32'h2);
    chk("to_staged",     32'(bus.tx_empty_o), 32'h0);
    bus.tx_re_i = 1'b1;
    step();
    bus.tx_re_i = 1'b0;
    drive(2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("to_rdC1", 32'(bus.tx_data_o), 32'hC1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
